// File: rtl/spi_burst_arbiter.sv
// rtl/spi_burst_arbiter.sv - two-requester round-robin burst sequencer for the SPI master register port
//
// Purpose:
//   Arbitrates multi-byte transfer commands from two clients and, for the
//   winner, drives the SPI core's register bus to select the slave, push each
//   TX byte, poll RRDY, read back each RX byte and release slave select.
//   Optional feature macro: SPI_BURST_TIMEOUT_EN (poll timeout with err pulse).
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_valid[1:0]               per-requester command request (held until gnt)
//   req_len0/1[3:0]              byte count, 0 encodes 16
//   req_ss0/1[NUM_SLAVES-1:0]    slave-select mask
//   tx_data0/1[7:0]              next TX byte of each requester
//   gnt[1:0]                     one-hot grant for the whole transaction
//   tx_pop                       granted requester's byte consumed
//   rx_data[7:0], rx_valid       received byte stream
//   done, err                    transaction end, timeout abort
//   spi_select, read_n, write_n  core bus strobes
//   mem_addr[2:0]                core register address
//   data_from_cpu[15:0]          core write data
//   data_to_cpu[15:0]            core read data
module spi_burst_arbiter #(
  parameter int NUM_SLAVES    = 1,
  parameter int TIMEOUT_POLLS = 1023
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            req_valid,
  input  logic [3:0]            req_len0,
  input  logic [3:0]            req_len1,
  input  logic [NUM_SLAVES-1:0] req_ss0,
  input  logic [NUM_SLAVES-1:0] req_ss1,
  input  logic [7:0]            tx_data0,
  input  logic [7:0]            tx_data1,
  output logic [1:0]            gnt,
  output logic                  tx_pop,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic                  done,
  output logic                  err,
  output logic                  spi_select,
  output logic                  read_n,
  output logic                  write_n,
  output logic [2:0]            mem_addr,
  output logic [15:0]           data_from_cpu,
  input  logic [15:0]           data_to_cpu
);

  typedef enum logic [3:0] {
    IDLE, ARB, CLR, SEL, SSO_ON, TXW, POLL, RXR, SSO_OFF, DONE
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            phase;        // 0 = A1, 1 = A2, 2 = G within a core access
  logic                  access, is_read, last_phase;
  logic                  cur, last, winner;
  logic [4:0]            byte_cnt;
  logic [NUM_SLAVES-1:0] ss_q;
  logic [7:0]            tx_byte;
  logic                  rrdy_q;
  logic                  poll_timeout, timed_out;

  assign access     = state inside {CLR, SEL, SSO_ON, TXW, POLL, RXR, SSO_OFF};
  assign is_read    = state inside {POLL, RXR};
  assign last_phase = (phase == 2'd2);

  // Last-served requester loses ties; reset leaves last=1 so requester 0 wins.
  assign winner = (req_valid == 2'b11) ? ~last : req_valid[1];

`ifdef SPI_BURST_TIMEOUT_EN
  localparam int PCW = ($clog2(TIMEOUT_POLLS + 1) > 10) ? $clog2(TIMEOUT_POLLS + 1) : 10;
  logic [PCW-1:0] poll_cnt;

  // poll_cnt holds the number of polls already completed, so the
  // TIMEOUT_POLLS-th failing poll is the one that sees TIMEOUT_POLLS-1.
  assign poll_timeout = (poll_cnt >= PCW'(TIMEOUT_POLLS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt  <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state == ARB) timed_out <= 1'b0;
      if (state == TXW) begin
        poll_cnt <= '0;
      end else if (state == POLL && last_phase) begin
        poll_cnt <= poll_cnt + 1'b1;
        if (!rrdy_q && poll_timeout) timed_out <= 1'b1;
      end
    end
  end
`else
  logic unused_cfg;
  assign poll_timeout = 1'b0;
  assign timed_out    = 1'b0;
  assign unused_cfg   = (TIMEOUT_POLLS != 0);
`endif

  logic unused_rdata;
  assign unused_rdata = ^data_to_cpu[15:8];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      phase <= 2'd0;
    end else begin
      state <= state_nxt;
      phase <= (access && !last_phase) ? phase + 2'd1 : 2'd0;
    end
  end

  // Next-state logic; access states advance only after their guard cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = ARB;
      ARB:     state_nxt = CLR;
      CLR:     if (last_phase) state_nxt = SEL;
      SEL:     if (last_phase) state_nxt = SSO_ON;
      SSO_ON:  if (last_phase) state_nxt = TXW;
      TXW:     if (last_phase) state_nxt = POLL;
      POLL:    if (last_phase) begin
                 if (rrdy_q)            state_nxt = RXR;
                 else if (poll_timeout) state_nxt = SSO_OFF;
               end
      RXR:     if (last_phase) state_nxt = (byte_cnt == 5'd0) ? SSO_OFF : TXW;
      SSO_OFF: if (last_phase) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus and status outputs
  always_comb begin
    spi_select    = access && !last_phase;
    read_n        = !(spi_select && is_read);
    write_n       = !(spi_select && !is_read);
    tx_pop        = (state == TXW) && (phase == 2'd0);
    done          = (state == DONE);
    err           = done && timed_out;
    mem_addr      = 3'd0;
    data_from_cpu = 16'h0000;
    case (state)
      CLR:     mem_addr = 3'd2;
      SEL:     begin
                 mem_addr = 3'd5;
                 data_from_cpu[NUM_SLAVES-1:0] = ss_q;
               end
      SSO_ON:  begin
                 mem_addr      = 3'd3;
                 data_from_cpu = 16'h0400;
               end
      TXW:     begin
                 mem_addr      = 3'd1;
                 data_from_cpu = {8'h00, tx_byte};
               end
      POLL:    mem_addr = 3'd2;
      RXR:     mem_addr = 3'd0;
      SSO_OFF: mem_addr = 3'd3;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt      <= 2'b00;
      cur      <= 1'b0;
      last     <= 1'b1;
      byte_cnt <= 5'd0;
      ss_q     <= '0;
      tx_byte  <= 8'h00;
      rrdy_q   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == IDLE && |req_valid) cur <= winner;
      if (state == ARB) begin
        gnt      <= cur ? 2'b10 : 2'b01;
        byte_cnt <= cur ? {req_len1 == 4'd0, req_len1} : {req_len0 == 4'd0, req_len0};
        ss_q     <= cur ? req_ss1 : req_ss0;
      end
      // Capture the byte before tx_pop lets the client move on, so the
      // write data stays stable across both access cycles.
      if (state_nxt == TXW && state != TXW) tx_byte <= cur ? tx_data1 : tx_data0;
      if (state == POLL && phase == 2'd1) rrdy_q <= data_to_cpu[7];
      if (state == RXR && phase == 2'd1) begin
        rx_data  <= data_to_cpu[7:0];
        rx_valid <= 1'b1;
        byte_cnt <= byte_cnt - 5'd1;
      end
      if (state == DONE) begin
        gnt  <= 2'b00;
        last <= cur;
      end
    end
  end

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// tb/tb_spi_burst_arbiter.sv - self-checking bench for spi_burst_arbiter
`timescale 1ns/1ps
module tb_spi_burst_arbiter;
  localparam int NS = 4;
`ifdef SPI_BURST_TIMEOUT_EN
  localparam int TP = 4;
`else
  localparam int TP = 1023;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [3:0]    req_len0 = 4'd0, req_len1 = 4'd0;
  logic [NS-1:0] req_ss0 = '0, req_ss1 = '0;
  logic [7:0]    tx_data0, tx_data1;
  logic [1:0]    gnt;
  logic          tx_pop, rx_valid, done, err, spi_select, read_n, write_n;
  logic [7:0]    rx_data;
  logic [2:0]    mem_addr;
  logic [15:0]   data_from_cpu, data_to_cpu;

  spi_burst_arbiter #(.NUM_SLAVES(NS), .TIMEOUT_POLLS(TP)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
    .req_len0(req_len0), .req_len1(req_len1), .req_ss0(req_ss0), .req_ss1(req_ss1),
    .tx_data0(tx_data0), .tx_data1(tx_data1), .gnt(gnt), .tx_pop(tx_pop),
    .rx_data(rx_data), .rx_valid(rx_valid), .done(done), .err(err),
    .spi_select(spi_select), .read_n(read_n), .write_n(write_n),
    .mem_addr(mem_addr), .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;

  // Client byte sources: each requester presents txbufN[k] after k pops.
  logic [7:0] txbuf0[16], txbuf1[16];
  int pop0 = 0, pop1 = 0, base0 = 0, base1 = 0;
  assign tx_data0 = txbuf0[4'(pop0 - base0)];
  assign tx_data1 = txbuf1[4'(pop1 - base1)];

  // SPI core model: loopback MOSI->MISO, RRDY after a random delay.
  logic       rrdy = 1'b0;
  logic [7:0] rx_reg = 8'h00;
  int         cd = 0;
  bit         block = 1'b0;
  assign data_to_cpu = (mem_addr == 3'd2) ? {8'h00, rrdy, 7'h00} :
                       (mem_addr == 3'd0) ? {8'h00, rx_reg} : 16'h0000;

  // Observed bus accesses {is_read, addr, data} and event counters.
  logic [19:0] ops[$];
  logic [7:0]  rx_got[$];
  logic [1:0]  gnt_hist[$];
  logic [1:0]  gnt_prev = 2'b00;
  int done_cnt = 0, err_cnt = 0, done_err_cnt = 0, viol = 0, run = 0;
  logic act;

  always @(negedge clk) begin
    if (!reset_n) begin
      run = 0; rrdy = 1'b0; cd = 0; gnt_prev = 2'b00;
    end else begin
      act = !read_n || !write_n;
      if (spi_select !== act) viol++;
      if (!read_n && !write_n) viol++;
      if (act) begin
        run++;
        if (run == 2) begin
          ops.push_back({!read_n, mem_addr, read_n ? data_from_cpu : data_to_cpu});
          if (!write_n && mem_addr == 3'd1) begin
            rx_reg = data_from_cpu[7:0];
            cd = 1 + int'($urandom_range(0, 12));
          end
          if (!write_n && mem_addr == 3'd2) rrdy = 1'b0;
          if (!read_n && mem_addr == 3'd0) rrdy = 1'b0;
        end
        if (run > 2) viol++;
      end else begin
        if (run != 0 && run != 2) viol++;
        run = 0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0 && !block) rrdy = 1'b1;
      end
      if (rx_valid) rx_got.push_back(rx_data);
      if (tx_pop) begin
        if (gnt[1]) pop1++;
        else pop0++;
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done && err) done_err_cnt++;
      if (gnt != gnt_prev && gnt != 2'b00) gnt_hist.push_back(gnt);
      gnt_prev = gnt;
    end
  end

  // Reference model: expected non-poll access sequence of one transaction.
  logic [19:0] exp_q[$], got_q[$];

  function automatic void build_exp(input int r, input int nb, input logic [NS-1:0] ss, input bit with_rx);
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back({1'b0, 3'd2, 16'h0000});
    exp_q.push_back({1'b0, 3'd5, 16'(ss)});
    exp_q.push_back({1'b0, 3'd3, 16'h0400});
    for (int i = 0; i < nb; i++) begin
      b = (r == 1) ? txbuf1[i] : txbuf0[i];
      exp_q.push_back({1'b0, 3'd1, 8'h00, b});
      if (with_rx) exp_q.push_back({1'b1, 3'd0, 8'h00, b});
    end
    exp_q.push_back({1'b0, 3'd3, 16'h0000});
  endfunction

  function automatic void collect(input int start);
    got_q.delete();
    for (int i = start; i < ops.size(); i++)
      if (ops[i][19:16] != 4'b1010) got_q.push_back(ops[i]);
  endfunction

  function automatic int count_polls(input int start);
    int n = 0;
    for (int i = start; i < ops.size(); i++)
      if (ops[i][19:16] == 4'b1010) n++;
    return n;
  endfunction

  function automatic void fill(input int r);
    for (int i = 0; i < 16; i++)
      if (r == 1) txbuf1[i] = 8'($urandom);
      else txbuf0[i] = 8'($urandom);
  endfunction

  task automatic start_req(input int r, input int len, input logic [NS-1:0] ss);
    if (r == 1) begin
      base1 = pop1; req_len1 = 4'(len); req_ss1 = ss; req_valid[1] = 1'b1;
    end else begin
      base0 = pop0; req_len0 = 4'(len); req_ss0 = ss; req_valid[0] = 1'b1;
    end
  endtask

  task automatic wait_any_gnt(output logic [1:0] g, output bit ok);
    ok = 1'b0; g = 2'b00;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin g = gnt; ok = 1'b1; break; end
    end
    req_valid = req_valid & ~g;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    @(negedge clk);
  endtask

  task automatic run_one(input int r, input int len, input logic [NS-1:0] ss, output bit ok);
    logic [1:0] g;
    bit okg, okd;
    start_req(r, len, ss);
    wait_any_gnt(g, okg);
    req_valid = 2'b00;
    wait_done(okd);
    ok = okg && okd;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; req_valid = 2'b00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [37:0] obs;
    logic [1:0]  g;
    bit ok, busy;
    obs = {gnt, tx_pop, rx_data, rx_valid, done, err, spi_select, read_n, write_n, mem_addr, data_from_cpu};
    compared++;
    if (obs !== {2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 16'h0000}) begin
      mismatched++; $display("FAIL reset_values got %h want %h", obs, {2'b00, 1'b0, 8'h00, 5'b00011, 3'd0, 16'h0000});
    end
    reset_n = 1'b1;
    fill(0); block = 1'b1;
    start_req(0, 2, 4'h3);
    wait_any_gnt(g, ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!read_n && mem_addr == 3'd2) begin ok = 1'b1; break; end
    end
    compared++;
    if (!ok) begin mismatched++; $display("FAIL reset_reach_poll got timeout want poll read"); end
    #1 reset_n = 1'b0;
    #1 compared++;
    if ({read_n, write_n, gnt, spi_select} !== 5'b11000) begin
      mismatched++; $display("FAIL reset_async got %b want 11000", {read_n, write_n, gnt, spi_select});
    end
    @(negedge clk);
    compared++;
    if ({read_n, write_n, gnt, spi_select, rx_valid, done} !== 7'b1100000) begin
      mismatched++; $display("FAIL reset_next_cycle got %b want 1100000", {read_n, write_n, gnt, spi_select, rx_valid, done});
    end
    reset_n = 1'b1; block = 1'b0;
    busy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      busy = busy | spi_select | !read_n | !write_n | (gnt != 2'b00);
    end
    compared++;
    if (busy) begin mismatched++; $display("FAIL reset_idle_bus got busy=1 want busy=0"); end
  endtask

  task automatic test_single();
    int os, rs, dc, ec, bad;
    bit ok;
    fill(0); txbuf0[0] = 8'hA5;
    os = ops.size(); rs = rx_got.size(); dc = done_cnt; ec = err_cnt;
    run_one(0, 1, 4'h1, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL single_complete got timeout want done"); end
    build_exp(0, 1, 4'h1, 1'b1);
    collect(os);
    compared++;
    if (got_q.size() != exp_q.size()) begin
      mismatched++; $display("FAIL single_ops_len got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        compared++;
        if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL single_op%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
    bad = 0;
    for (int i = os; i < ops.size(); i++)
      if (ops[i][19:16] == 4'b1000 && (i == os || ops[i-1][19:16] != 4'b1010 || !ops[i-1][7])) bad++;
    compared++;
    if (bad != 0 || count_polls(os) < 1) begin
      mismatched++; $display("FAIL single_poll_rule got bad=%0d polls=%0d want bad=0 polls>=1", bad, count_polls(os));
    end
    compared++;
    if (rx_got.size() != rs + 1 || rx_got[rs] !== 8'hA5) begin
      mismatched++; $display("FAIL single_rx got n=%0d want 1 byte A5", rx_got.size() - rs);
    end
    compared++;
    if (done_cnt - dc != 1 || err_cnt != ec) begin
      mismatched++; $display("FAIL single_done got done=%0d err=%0d want 1/0", done_cnt - dc, err_cnt - ec);
    end
  endtask

  task automatic test_len16();
    int os, rs, dc, pc;
    bit ok;
    logic [NS-1:0] ss;
    fill(1); ss = NS'($urandom_range(1, 15));
    os = ops.size(); rs = rx_got.size(); dc = done_cnt; pc = pop1;
    run_one(1, 16, ss, ok);
    compared++;
    if (!ok || pop1 - pc != 16 || rx_got.size() - rs != 16 || done_cnt - dc != 1) begin
      mismatched++; $display("FAIL len16_counts got pop=%0d rx=%0d done=%0d want 16/16/1", pop1 - pc, rx_got.size() - rs, done_cnt - dc);
    end else begin
      for (int i = 0; i < 16; i++) begin
        compared++;
        if (rx_got[rs+i] !== txbuf1[i]) begin mismatched++; $display("FAIL len16_rx%0d got %h want %h", i, rx_got[rs+i], txbuf1[i]); end
      end
    end
    build_exp(1, 16, ss, 1'b1);
    collect(os);
    compared++;
    if (got_q != exp_q) begin mismatched++; $display("FAIL len16_ops got n=%0d want n=%0d (contents differ)", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_rr();
    logic [1:0] g;
    logic [1:0] want[4];
    bit ok, okd;
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
    apply_reset();
    fill(0); fill(1);
    for (int k = 0; k < 4; k++) begin
      if (k == 0 || k == 2) begin
        start_req(0, 1, 4'h1);
        start_req(1, 1, 4'h2);
      end
      wait_any_gnt(g, ok);
      wait_done(okd);
      compared++;
      if (!ok || !okd || g !== want[k]) begin
        mismatched++; $display("FAIL rr_grant%0d got %b want %b", k, g, want[k]);
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_random();
    int os, rs, dc, r, len;
    bit ok;
    logic [NS-1:0] ss;
    for (int t = 0; t < 6; t++) begin
      r = int'($urandom_range(0, 1)); len = int'($urandom_range(1, 16));
      ss = NS'($urandom); fill(r);
      os = ops.size(); rs = rx_got.size(); dc = done_cnt;
      run_one(r, len, ss, ok);
      build_exp(r, len, ss, 1'b1);
      collect(os);
      compared++;
      if (!ok || got_q != exp_q) begin
        mismatched++; $display("FAIL rand%0d_ops r=%0d len=%0d got n=%0d want n=%0d", t, r, len, got_q.size(), exp_q.size());
      end
      compared++;
      if (rx_got.size() - rs != len || done_cnt - dc != 1) begin
        mismatched++; $display("FAIL rand%0d_counts got rx=%0d done=%0d want %0d/1", t, rx_got.size() - rs, done_cnt - dc, len);
      end
    end
`ifndef SPI_BURST_TIMEOUT_EN
    compared++;
    if (err_cnt != 0) begin mismatched++; $display("FAIL err_tied got %0d pulses want 0", err_cnt); end
`endif
  endtask

  task automatic test_spacing();
    int v0;
    bit ok;
    v0 = viol; fill(0);
    run_one(0, 4, 4'h5, ok);
    compared++;
    if (!ok || viol != v0) begin mismatched++; $display("FAIL spacing got violations=%0d want 0", viol - v0); end
  endtask

`ifdef SPI_BURST_TIMEOUT_EN
  task automatic test_timeout();
    int os, rs, dc, pc;
    bit ok;
    fill(0); block = 1'b1;
    os = ops.size(); rs = rx_got.size(); dc = done_err_cnt; pc = pop0;
    run_one(0, 3, 4'h1, ok);
    block = 1'b0;
    build_exp(0, 1, 4'h1, 1'b0);
    collect(os);
    compared++;
    if (!ok || got_q != exp_q) begin mismatched++; $display("FAIL timeout_ops got n=%0d want n=%0d", got_q.size(), exp_q.size()); end
    compared++;
    if (count_polls(os) != 4) begin mismatched++; $display("FAIL timeout_polls got %0d want 4", count_polls(os)); end
    compared++;
    if (done_err_cnt - dc != 1 || rx_got.size() != rs || pop0 - pc != 1) begin
      mismatched++; $display("FAIL timeout_flags got done_err=%0d rx=%0d pop=%0d want 1/0/1", done_err_cnt - dc, rx_got.size() - rs, pop0 - pc);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) begin txbuf0[i] = 8'h00; txbuf1[i] = 8'h00; end
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_len16();
    test_rr();
    test_random();
    test_spacing();
`ifdef SPI_BURST_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
